// File: rtl/iic_slave_regif.sv
// I2C target: START/STOP detect, 7-bit device match, register pointer, write strobes and read requests.
// Latency: 2-flop sync (+FILT_LEN clks with IIC_SLAVE_GLITCH_FILTER_EN) from bus pins to bit decisions; wr_en/rd_req on the SCL rise.
// Backpressure: none; the register file must accept wr_en and answer rd_req on the next clk.
module iic_slave_regif #(
    parameter logic [6:0] DEV_ADDR = 7'h50,
    parameter int         FILT_LEN = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iic_clk,
    inout  wire        iic_sda,
    output logic [7:0] reg_addr,
    output logic [7:0] wr_data,
    output logic       wr_en,
    output logic       rd_req,
    input  logic [7:0] rd_data,
    output logic       busy
);

    typedef enum logic [3:0] {
        S_IDLE, S_DEV_ADDR, S_DEV_ACK, S_REG_ADDR, S_REG_ACK,
        S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_IGNORE
    } state_t;

    state_t     state, state_nxt;
    logic       scl_s1, scl_s2, sda_s1, sda_s2;
    logic       scl_f, sda_f, scl_p, sda_p;
    logic [2:0] bit_cnt, bit_cnt_nxt;
    logic [7:0] sr, sr_nxt, rd_byte, rd_byte_nxt, byte_in;
    logic [7:0] reg_addr_nxt, wr_data_nxt;
    logic       sda_oe, sda_oe_nxt, ack_drv, ack_drv_nxt, rw, rw_nxt;
    logic       wr_en_nxt, rd_req_nxt, busy_nxt;
    logic       scl_rise, scl_fall, sda_rise, sda_fall, start_det, stop_det;

    // Open-drain: only ever pull low or release.
    assign iic_sda = sda_oe ? 1'b0 : 1'bz;

    // Two-flop synchronizers; idle bus level is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_s1 <= 1'b1; scl_s2 <= 1'b1; sda_s1 <= 1'b1; sda_s2 <= 1'b1;
        end else begin
            scl_s1 <= iic_clk; scl_s2 <= scl_s1;
            sda_s1 <= iic_sda; sda_s2 <= sda_s1;
        end
    end

`ifdef IIC_SLAVE_GLITCH_FILTER_EN
    logic [7:0] scl_cnt, sda_cnt;

    // Debounce: a line's level follows the synchronizer only after FILT_LEN equal differing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_f <= 1'b1; sda_f <= 1'b1; scl_cnt <= '0; sda_cnt <= '0;
        end else begin
            if (scl_s2 == scl_f)                    scl_cnt <= '0;
            else if (scl_cnt == 8'(FILT_LEN - 1)) begin scl_f <= scl_s2; scl_cnt <= '0; end
            else                                    scl_cnt <= scl_cnt + 8'd1;
            if (sda_s2 == sda_f)                    sda_cnt <= '0;
            else if (sda_cnt == 8'(FILT_LEN - 1)) begin sda_f <= sda_s2; sda_cnt <= '0; end
            else                                    sda_cnt <= sda_cnt + 8'd1;
        end
    end
`else
    // FILT_LEN only matters when the filter is built.
    logic [31:0] filt_len_unused;
    assign filt_len_unused = FILT_LEN;
    assign scl_f = scl_s2;
    assign sda_f = sda_s2;
`endif

    // Previous-sample register for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_p <= 1'b1; sda_p <= 1'b1;
        end else begin
            scl_p <= scl_f; sda_p <= sda_f;
        end
    end

    assign scl_rise  = scl_f & ~scl_p;
    assign scl_fall  = ~scl_f & scl_p;
    assign sda_rise  = sda_f & ~sda_p;
    assign sda_fall  = ~sda_f & sda_p;
    assign start_det = sda_fall & scl_f;
    assign stop_det  = sda_rise & scl_f;
    assign byte_in   = {sr[6:0], sda_f};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt <= '0; sr <= '0; rd_byte <= '0; sda_oe <= 1'b0; ack_drv <= 1'b0; rw <= 1'b0;
            reg_addr <= '0; wr_data <= '0; wr_en <= 1'b0; rd_req <= 1'b0; busy <= 1'b0;
        end else begin
            bit_cnt <= bit_cnt_nxt; sr <= sr_nxt; rd_byte <= rd_byte_nxt; sda_oe <= sda_oe_nxt;
            ack_drv <= ack_drv_nxt; rw <= rw_nxt; reg_addr <= reg_addr_nxt; wr_data <= wr_data_nxt;
            wr_en <= wr_en_nxt; rd_req <= rd_req_nxt; busy <= busy_nxt;
        end
    end

    // Next-state and datapath decisions; START/STOP override any bit activity in the same clk.
    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        sr_nxt       = sr;
        rd_byte_nxt  = rd_byte;
        sda_oe_nxt   = sda_oe;
        ack_drv_nxt  = ack_drv;
        rw_nxt       = rw;
        reg_addr_nxt = reg_addr;
        wr_data_nxt  = wr_data;
        wr_en_nxt    = 1'b0;
        rd_req_nxt   = 1'b0;
        busy_nxt     = busy;
        // Register file answers a read request on the following clk.
        if (rd_req) rd_byte_nxt = rd_data;
        if (start_det) begin
            state_nxt = S_DEV_ADDR; bit_cnt_nxt = '0; sda_oe_nxt = 1'b0; ack_drv_nxt = 1'b0;
        end else if (stop_det) begin
            state_nxt = S_IDLE; sda_oe_nxt = 1'b0; ack_drv_nxt = 1'b0; busy_nxt = 1'b0;
        end else begin
            case (state)
                S_DEV_ADDR, S_REG_ADDR, S_WR_DATA: begin
                    if (scl_rise) begin
                        sr_nxt      = byte_in;
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (state == S_DEV_ADDR) begin
                                if (byte_in[7:1] == DEV_ADDR) begin
                                    state_nxt = S_DEV_ACK; busy_nxt = 1'b1; rw_nxt = byte_in[0];
                                end else begin
                                    state_nxt = S_IGNORE; busy_nxt = 1'b0;
                                end
                            end else if (state == S_REG_ADDR) begin
                                reg_addr_nxt = byte_in; state_nxt = S_REG_ACK;
                            end else begin
                                wr_data_nxt = byte_in; wr_en_nxt = 1'b1; state_nxt = S_WR_ACK;
                            end
                        end
                    end
                end
                S_DEV_ACK, S_REG_ACK, S_WR_ACK: begin
                    // Read addressing fetches the first byte on the 9th rise.
                    if (scl_rise && ack_drv && state == S_DEV_ACK && rw) rd_req_nxt = 1'b1;
                    if (scl_fall) begin
                        if (!ack_drv) begin
                            sda_oe_nxt = 1'b1; ack_drv_nxt = 1'b1;
                        end else begin
                            ack_drv_nxt = 1'b0; bit_cnt_nxt = '0; sda_oe_nxt = 1'b0;
                            if (state == S_DEV_ACK) begin
                                if (rw) begin
                                    state_nxt = S_RD_DATA; sda_oe_nxt = ~rd_byte[7];
                                end else begin
                                    state_nxt = S_REG_ADDR;
                                end
                            end else if (state == S_REG_ACK) begin
                                state_nxt = S_WR_DATA;
                            end else begin
                                state_nxt = S_WR_DATA; reg_addr_nxt = reg_addr + 8'd1;
                            end
                        end
                    end
                end
                S_RD_DATA: begin
                    if (scl_fall) begin
                        if (bit_cnt == 3'd7) begin
                            sda_oe_nxt = 1'b0; state_nxt = S_RD_ACK; bit_cnt_nxt = '0; ack_drv_nxt = 1'b0;
                        end else begin
                            sda_oe_nxt  = ~rd_byte[6];
                            rd_byte_nxt = {rd_byte[6:0], 1'b0};
                            bit_cnt_nxt = bit_cnt + 3'd1;
                        end
                    end
                end
                S_RD_ACK: begin
                    // ack_drv here marks "master acked, next byte pending".
                    if (scl_rise && !ack_drv) begin
                        reg_addr_nxt = reg_addr + 8'd1;
                        if (!sda_f) begin
                            rd_req_nxt = 1'b1; ack_drv_nxt = 1'b1;
                        end else begin
                            state_nxt = S_IGNORE;
                        end
                    end
                    if (scl_fall && ack_drv) begin
                        state_nxt = S_RD_DATA; sda_oe_nxt = ~rd_byte[7]; ack_drv_nxt = 1'b0; bit_cnt_nxt = '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
